mux_64_32: RTL and testbench



---
 rtl/mux_64_32.sv | 52 +++++
 tb/tb_mux_64_32.sv | 117 +++++++++++
 2 files changed

// File: rtl/mux_64_32.sv
// mux_64_32: 32-bit 2:1 datapath selector with registered copy and status flags (optional parity via MUX_64_32_PARITY_EN)
module mux_64_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s,
  output logic [31:0] c,
  output logic [31:0] c_q,
  output logic        s_q,
  output logic        zero_q,
  output logic        chg_q
`ifdef MUX_64_32_PARITY_EN
  ,
  output logic        par,
  output logic        par_q
`endif
);
  logic        zero_d;
  logic        chg_d;
  // Select the operand and derive next-cycle status flags from it
  always_comb begin
    c      = s ? b : a;
    zero_d = c == '0;
    chg_d  = c != c_q;
  end
  // Pipeline copy of the selected word; reset forces a defined zero word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= '0;
      s_q    <= 1'b0;
      zero_q <= 1'b1;
      chg_q  <= 1'b0;
    end else begin
      c_q    <= c;
      s_q    <= s;
      zero_q <= zero_d;
      chg_q  <= chg_d;
    end
  end
`ifdef MUX_64_32_PARITY_EN
  logic par_d;
  // Even parity of the selected word
  always_comb par_d = ^c;
  assign par = par_d;
  // Registered parity tracks c_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif
endmodule

// File: tb/tb_mux_64_32.sv
// tb_mux_64_32: directed self-checking bench for mux_64_32
module tb_mux_64_32;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        s = 1'b0;
  logic [31:0] c, c_q;
  logic        s_q, zero_q, chg_q;
`ifdef MUX_64_32_PARITY_EN
  logic        par, par_q;
`endif
  int checks = 0;
  int errors = 0;

  mux_64_32 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s),
    .c(c), .c_q(c_q), .s_q(s_q), .zero_q(zero_q), .chg_q(chg_q)
`ifdef MUX_64_32_PARITY_EN
    , .par(par), .par_q(par_q)
`endif
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] c;
    logic [31:0] cq;
    logic        sq;
    logic        zq;
    logic        chg;
    logic        par;
  } vec_t;

  vec_t v [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  initial begin
    v[0] = '{a:32'h12345678, b:32'hFFFFFFFF, s:1'b1, c:32'hFFFFFFFF, cq:32'hFFFFFFFF, sq:1'b1, zq:1'b0, chg:1'b1, par:1'b0};
    v[1] = '{a:32'h12345678, b:32'hFFFFFFFF, s:1'b1, c:32'hFFFFFFFF, cq:32'hFFFFFFFF, sq:1'b1, zq:1'b0, chg:1'b0, par:1'b0};
    v[2] = '{a:32'h00000000, b:32'hFFFFFFFF, s:1'b0, c:32'h00000000, cq:32'h00000000, sq:1'b0, zq:1'b1, chg:1'b1, par:1'b0};
    v[3] = '{a:32'h00000000, b:32'h80000000, s:1'b1, c:32'h80000000, cq:32'h80000000, sq:1'b1, zq:1'b0, chg:1'b1, par:1'b1};
    v[4] = '{a:32'h00000000, b:32'h80000000, s:1'b0, c:32'h00000000, cq:32'h00000000, sq:1'b0, zq:1'b1, chg:1'b1, par:1'b0};
    v[5] = '{a:32'h00000000, b:32'h80000000, s:1'b1, c:32'h80000000, cq:32'h80000000, sq:1'b1, zq:1'b0, chg:1'b1, par:1'b1};
    v[6] = '{a:32'h00000000, b:32'h80000000, s:1'b0, c:32'h00000000, cq:32'h00000000, sq:1'b0, zq:1'b1, chg:1'b1, par:1'b0};
    v[7] = '{a:32'h00000000, b:32'h80000000, s:1'b0, c:32'h00000000, cq:32'h00000000, sq:1'b0, zq:1'b1, chg:1'b0, par:1'b0};
    v[8] = '{a:32'h00000007, b:32'h80000000, s:1'b0, c:32'h00000007, cq:32'h00000007, sq:1'b0, zq:1'b0, chg:1'b1, par:1'b1};
    v[9] = '{a:32'h00000003, b:32'h80000000, s:1'b0, c:32'h00000003, cq:32'h00000003, sq:1'b0, zq:1'b0, chg:1'b1, par:1'b0};

    a = 32'd0; b = 32'd40; s = 1'b1;
    #1 check("comb_b", c, 32'd40);
    a = 32'd30; b = 32'd0; s = 1'b0;
    #1 check("comb_a", c, 32'd30);

    a = 32'd5; s = 1'b0; rst = 1'b1;
    #1;
    check("rst_c", c, 32'd5);
    check("rst_c_q", c_q, 32'd0);
    check("rst_s_q", {31'd0, s_q}, 32'd0);
    check("rst_zero_q", {31'd0, zero_q}, 32'd1);
    check("rst_chg_q", {31'd0, chg_q}, 32'd0);
`ifdef MUX_64_32_PARITY_EN
    check("rst_par_q", {31'd0, par_q}, 32'd0);
`endif
    #2 rst = 1'b0;
    #2;

    for (int i = 0; i < 10; i++) begin
      a = v[i].a; b = v[i].b; s = v[i].s;
      #1;
      check($sformatf("v%0d_c", i), c, v[i].c);
`ifdef MUX_64_32_PARITY_EN
      check($sformatf("v%0d_par", i), {31'd0, par}, {31'd0, v[i].par});
`endif
      tick();
      check($sformatf("v%0d_c_q", i), c_q, v[i].cq);
      check($sformatf("v%0d_s_q", i), {31'd0, s_q}, {31'd0, v[i].sq});
      check($sformatf("v%0d_zero_q", i), {31'd0, zero_q}, {31'd0, v[i].zq});
      check($sformatf("v%0d_chg_q", i), {31'd0, chg_q}, {31'd0, v[i].chg});
`ifdef MUX_64_32_PARITY_EN
      check($sformatf("v%0d_par_q", i), {31'd0, par_q}, {31'd0, v[i].par});
`endif
    end

    a = 32'h0; b = 32'hFFFFFFFF; s = 1'b1;
    tick();
    check("pre_async_c_q", c_q, 32'hFFFFFFFF);
    #2 rst = 1'b1;
    #1;
    check("async_c_q", c_q, 32'd0);
    check("async_zero_q", {31'd0, zero_q}, 32'd1);
    check("async_s_q", {31'd0, s_q}, 32'd0);
    check("async_chg_q", {31'd0, chg_q}, 32'd0);
    check("async_c", c, 32'hFFFFFFFF);
    #1 rst = 1'b0;
    tick();
    check("post_rst_c_q", c_q, 32'hFFFFFFFF);
    check("post_rst_chg_q", {31'd0, chg_q}, 32'd1);
    check("post_rst_zero_q", {31'd0, zero_q}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
